uart_tx_fsm: RTL and testbench

//  Transmit side of the UART link; counterpart of the receiver FSM (d_ready/p_error/d_load side).

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_tx_fsm.sv | 137 +++++++++++++
 tb/tb_uart_tx_fsm.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line-level bit values
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: bit_tick marks the last clk of every CLKS_PER_BIT-cycle bit period.
// clear holds the count at zero so the first period starts exactly on a frame accept.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Reloading on every tick keeps each period exactly CLKS_PER_BIT long.
    always_ff @(posedge clk) begin
        if (rst || clear || bit_tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_tick = (count == LAST);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to include the parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_fsm #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    import uart_pkg::*;

    localparam int BW = $clog2(WIDTH);

    if ((WIDTH < 5) || (WIDTH > 9) || (CLKS_PER_BIT < 2) || (STOP_BITS < 1) || (STOP_BITS > 2)
        || (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_params
        $error("uart_tx_fsm: parameter out of range");
    end

    tx_state_t      state, state_next;
    logic [WIDTH-1:0] shift, shift_next;
    logic [BW-1:0]  bit_cnt, bit_cnt_next;
    logic           tx_next, done_next;
    logic           bit_tick, accept, last_data, last_stop;

    assign d_ready   = (state == IDLE);
    assign accept    = d_ready && d_valid;
    assign last_data = (bit_cnt == BW'(WIDTH - 1));
    assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (d_ready),
        .bit_tick(bit_tick)
    );

`ifdef UART_TX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    logic parity;

    // Parity comes from the word as accepted, not the shifting copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (accept) begin
            parity <= (^d_in) ^ ODD;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= STOP_BIT;
            busy    <= 1'b0;
            done    <= 1'b0;
            shift   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            tx      <= tx_next;
            busy    <= (state_next != IDLE);
            done    <= done_next;
            shift   <= shift_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (d_valid)  state_next = START;
            START:  if (bit_tick) state_next = DATA;
            DATA: begin
                if (bit_tick && last_data) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
            PARITY: if (bit_tick) state_next = STOP;
            STOP:   if (bit_tick && last_stop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tx is driven from the next state so the line changes on the same edge as the state.
    always_comb begin
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        tx_next      = STOP_BIT;
        done_next    = 1'b0;

        if (accept) begin
            shift_next = d_in;
        end else if ((state == DATA) && bit_tick && !last_data) begin
            shift_next = shift >> 1;
        end

        if (bit_tick && (state != IDLE)) begin
            if (((state == DATA) && !last_data) || ((state == STOP) && !last_stop)) begin
                bit_cnt_next = bit_cnt + BW'(1);
            end else begin
                bit_cnt_next = '0;
            end
        end

        case (state_next)
            IDLE:   tx_next = STOP_BIT;
            START:  tx_next = START_BIT;
            DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_next = parity;
`else
            PARITY: tx_next = STOP_BIT;
`endif
            STOP:   tx_next = STOP_BIT;
            default: tx_next = STOP_BIT;
        endcase

        done_next = (state == STOP) && bit_tick && last_stop;
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm (WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1): an even-parity and an
// odd-parity instance share inputs; expected frames follow UART_TX_PARITY_EN as the RTL does.
module tb_uart_tx_fsm;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME_BITS   = 1 + 8 + P + 1;
    localparam int FRAME_CYCLES = FRAME_BITS * CPB;

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        logic       par_odd;
        int         inject_at;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d_in = 8'h00;
    logic       d_valid = 1'b0;
    logic       d_ready, tx, busy, done;
    logic       d_ready_odd, tx_odd, busy_odd, done_odd;

    int checks = 0;
    int errors = 0;
    int cur_cycle = 0;

    vec_t vecs[4];

    uart_tx_fsm #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid),
        .d_ready(d_ready), .tx(tx), .busy(busy), .done(done)
    );

    uart_tx_fsm #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid),
        .d_ready(d_ready_odd), .tx(tx_odd), .busy(busy_odd), .done(done_odd)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        d_valid = valid;
        d_in    = data;
    endtask

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got %b, want %b", name, cur_cycle, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic frameBit(input logic [7:0] data, input logic par, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return data[b-1];
        if ((P == 1) && (b == 9)) return par;
        return 1'b1;
    endfunction

    // Called #1 after the accepting edge; returns #1 after the edge that raises done.
    task automatic checkFrame(input logic [7:0] data, input logic pe, input logic po, input int inject_at);
        for (int cyc = 0; cyc < FRAME_CYCLES; cyc++) begin
            cur_cycle = cyc;
            if (inject_at >= 0 && cyc == inject_at) applyStimulus(1'b1, 8'h3C);
            if (inject_at >= 0 && cyc == inject_at + CPB) applyStimulus(1'b0, 8'h00);
            checkOutput("tx", tx, frameBit(data, pe, cyc / CPB));
            checkOutput("tx_odd", tx_odd, frameBit(data, po, cyc / CPB));
            checkOutput("d_ready_busy", d_ready, 1'b0);
            checkOutput("d_ready_odd_busy", d_ready_odd, 1'b0);
            checkOutput("busy", busy, 1'b1);
            checkOutput("done_early", done, 1'b0);
            step();
        end
        cur_cycle = FRAME_CYCLES;
        checkOutput("done", done, 1'b1);
        checkOutput("done_odd", done_odd, 1'b1);
        checkOutput("busy_end", busy, 1'b0);
        checkOutput("d_ready_end", d_ready, 1'b1);
        checkOutput("tx_end", tx, 1'b1);
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic pe, input logic po, input int inject_at);
        checkOutput("d_ready_idle", d_ready, 1'b1);
        applyStimulus(1'b1, data);
        step();
        applyStimulus(1'b0, 8'h00);
        checkFrame(data, pe, po, inject_at);
        step();
        cur_cycle = FRAME_CYCLES + 1;
        checkOutput("done_pulse_width", done, 1'b0);
        checkOutput("tx_idle", tx, 1'b1);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, par_even: 1'b0, par_odd: 1'b1, inject_at: 10};
        vecs[1] = '{data: 8'h81, par_even: 1'b0, par_odd: 1'b1, inject_at: -1};
        vecs[2] = '{data: 8'h07, par_even: 1'b1, par_odd: 1'b0, inject_at: -1};
        vecs[3] = '{data: 8'h01, par_even: 1'b1, par_odd: 1'b0, inject_at: 17};

        // Reset state and quiet line
        rst = 1'b1;
        step();
        step();
        checkOutput("rst_tx", tx, 1'b1);
        checkOutput("rst_d_ready", d_ready, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cur_cycle = i;
            step();
            checkOutput("idle_tx", tx, 1'b1);
            checkOutput("idle_busy", busy, 1'b0);
        end

        for (int i = 0; i < 4; i++) begin
            $display("[TB] frame %0d data=%02h", i, vecs[i].data);
            sendFrame(vecs[i].data, vecs[i].par_even, vecs[i].par_odd, vecs[i].inject_at);
        end

        // Reset during DATA bit 3 aborts the frame without a done pulse
        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 8'hA5);
        step();
        applyStimulus(1'b0, 8'h00);
        for (int i = 0; i < 17; i++) step();
        cur_cycle = 17;
        checkOutput("mid_tx_is_bit3", tx, 1'b0);
        rst = 1'b1;
        step();
        cur_cycle = 18;
        checkOutput("abort_tx", tx, 1'b1);
        checkOutput("abort_d_ready", d_ready, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        rst = 1'b0;
        step();
        cur_cycle = 19;
        checkOutput("abort_no_done", done, 1'b0);
        checkOutput("abort_tx_idle", tx, 1'b1);
        sendFrame(8'h5A, 1'b0, 1'b1, -1);

        // Back-to-back frames with d_valid held high
        $display("[TB] back-to-back");
        applyStimulus(1'b1, 8'h00);
        step();
        applyStimulus(1'b1, 8'hFF);
        checkFrame(8'h00, 1'b0, 1'b1, -1);
        step();
        applyStimulus(1'b0, 8'h00);
        checkFrame(8'hFF, 1'b0, 1'b1, -1);
        step();
        cur_cycle = FRAME_CYCLES + 1;
        checkOutput("b2b_done_clear", done, 1'b0);
        checkOutput("b2b_tx_idle", tx, 1'b1);
        checkOutput("b2b_busy_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
